serial_transmitter: RTL and testbench

Parallel-to-serial UART transmitter that is the sending end of the 22-bit serial link consumed by `Receiver_wrapper`. It accepts a 20-bit message through a valid/ready handshake and buffers one message behind the frame on the wire. Each frame is one start bit (1), 20 data bits MSB first, and one stop bit (0); the line idles low. It sits on the FPGA side that drives the serial line toward the receiving board.

---
 rtl/serial_transmitter.sv | 158 +++++++++++++++
 tb/tb_serial_transmitter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// serial_transmitter
//
// Parallel-to-serial transmitter that drives the 22-bit serial link toward the
// receiving board. A 20-bit message is accepted through a valid/ready
// handshake into a one-deep holding register. From there it moves into a
// 22-bit shifter and goes out MSB first as {start=1, message[19:0], stop=0}.
// The line idles low. After every stop bit the line stays low for at least
// GAP_BITS bit periods. A queued message then follows immediately, with no
// extra idle cycle.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   GAP_BITS      minimum idle-low bit periods after each stop bit (>= 1)
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   message    in  20   payload, sampled on an accepted handshake
//   send       in   1   request; handshake on a rising edge with send && ready
//   ready      out  1   holding register empty
//   serialOut  out  1   registered serial line
//   busy       out  1   frame or gap in progress, or holding register full
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_BITS     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] message,
  input  logic        send,
  output logic        ready,
  output logic        serialOut,
  output logic        busy
);

  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int GW       = $clog2(GAP_CLKS);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [4:0]    IDX_LAST = 5'd21;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t        state,      state_d;
  logic          hold_valid, hold_valid_d;
  logic [19:0]   hold;
  logic [21:0]   shifter,    shifter_d;
  logic [CW-1:0] bit_cnt,    bit_cnt_d;
  logic [4:0]    bit_idx,    bit_idx_d;
  logic [GW-1:0] gap_cnt,    gap_cnt_d;
  logic          serial_q,   serial_d;
  logic          accept;
  logic          load;

  assign ready     = !hold_valid;
  assign busy      = (state != IDLE) || hold_valid;
  assign serialOut = serial_q;
  assign accept    = send && ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state;
    shifter_d    = shifter;
    bit_cnt_d    = bit_cnt;
    bit_idx_d    = bit_idx;
    gap_cnt_d    = gap_cnt;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (hold_valid) load = 1'b1;
      end

      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = '0;
          shifter_d = {shifter[20:0], 1'b0};
          if (bit_idx == IDX_LAST) begin
            bit_idx_d = '0;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_d = '0;
          // A queued message goes straight back onto the wire.
          if (hold_valid) load = 1'b1;
          else            state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      shifter_d = {1'b1, hold, 1'b0};
      bit_cnt_d = '0;
      bit_idx_d = '0;
      gap_cnt_d = '0;
      state_d   = SHIFT;
    end

    // A load needs hold_valid, and an accept needs !hold_valid, so the two
    // never happen on the same edge.
    if (load)        hold_valid_d = 1'b0;
    else if (accept) hold_valid_d = 1'b1;
    else             hold_valid_d = hold_valid;

    // The line is registered from the next-state values. This keeps the start
    // bit on the wire one edge after the load, with no output glitch.
    serial_d = (state_d == SHIFT) && shifter_d[21];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (!reset_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      shifter    <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      serial_q   <= 1'b0;
    end else begin
      state      <= state_d;
      hold_valid <= hold_valid_d;
      shifter    <= shifter_d;
      bit_cnt    <= bit_cnt_d;
      bit_idx    <= bit_idx_d;
      gap_cnt    <= gap_cnt_d;
      serial_q   <= serial_d;
    end
  end

  // NOTE: the payload register has no reset. hold_valid qualifies it, and it
  // is only ever read after a handshake has written it.
  always_ff @(posedge clock) begin
    if (accept) hold <= message;
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter.
// The reference model works on whole frames. It tracks the start cycle of the
// frame on the wire and a one-deep queue of accepted messages. From those it
// derives the expected line level, ready and busy with plain arithmetic on
// the cycle count.
module tb_serial_transmitter;

  localparam int CPB   = 8;
  localparam int GAPB  = 1;
  localparam int FRAME = 22 * CPB;
  localparam int SPAN  = FRAME + GAPB * CPB;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] message = '0;
  logic        send = 1'b0;
  logic        ready;
  logic        serialOut;
  logic        busy;

  serial_transmitter #(
    .CLKS_PER_BIT (CPB),
    .GAP_BITS     (GAPB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .message   (message),
    .send      (send),
    .ready     (ready),
    .serialOut (serialOut),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int          t  = 0;          // rising edges since time zero
  bit          fa = 1'b0;       // a frame (or its gap) is in progress
  int          fs = 0;          // edge at which that frame's start bit began
  logic [19:0] fmsg = '0;
  bit          hv = 1'b0;       // queued message present
  logic [19:0] hmsg = '0;

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", tag, t, got, exp);
    end
  endtask

  function automatic logic exp_line();
    int off;
    int k;
    logic v;
    v = 1'b0;
    if (fa) begin
      off = t - fs;
      if (off < FRAME) begin
        k = off / CPB;
        if (k == 0)       v = 1'b1;
        else if (k <= 20) v = fmsg[20 - k];
        else              v = 1'b0;
      end
    end
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".serialOut"}, {21'd0, serialOut}, {21'd0, exp_line()});
    check({tag, ".ready"},     {21'd0, ready},     {21'd0, !hv});
    check({tag, ".busy"},      {21'd0, busy},      {21'd0, (fa || hv)});
  endtask

  // One clock edge with the given request, then advance the model and compare.
  task automatic step(input logic s, input logic [19:0] m, input string tag);
    bit pre_hv;
    send    = s;
    message = m;
    @(posedge clock);
    t++;
    pre_hv = hv;
    if (fa && (t - fs) >= SPAN) fa = 1'b0;
    if (!fa && pre_hv) begin
      fa   = 1'b1;
      fs   = t;
      fmsg = hmsg;
      hv   = 1'b0;
    end else if (s && !pre_hv) begin
      hv   = 1'b1;
      hmsg = m;
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 20'h0, tag);
  endtask

  // Asynchronous reset asserted between edges; hold for three edges.
  task automatic do_reset(input string tag);
    send    = 1'b0;
    reset_n = 1'b0;
    fa = 1'b0;
    hv = 1'b0;
    #1;
    compare_all({tag, ".async"});
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      t++;
      #1;
      compare_all({tag, ".held"});
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset and long idle
    do_reset("reset");
    idle(200, "idle");

    // Single frame with the documented bit pattern
    step(1'b1, 20'hABCDE, "single.hs");
    idle(200, "single");

    // Back-to-back: second message 5 cycles later, then a dropped request
    step(1'b1, 20'h00001, "b2b.hs1");
    idle(4, "b2b.wait");
    step(1'b1, 20'hFFFFF, "b2b.hs2");
    idle(10, "b2b.run");
    step(1'b1, 20'h12345, "drop.hs");
    step(1'b1, 20'h12345, "drop.hs");
    idle(400, "b2b.tail");

    // Reset mid-frame at bit index 10 with a message queued
    step(1'b1, 20'h3C3C3, "midrst.hs1");
    idle(5, "midrst.wait");
    step(1'b1, 20'h55555, "midrst.hs2");
    idle(79, "midrst.run");
    do_reset("midrst");
    step(1'b1, 20'h0F0F0, "post.hs");
    idle(200, "post");

    // Payloads that form a checked sequence, including the receiver error code
    step(1'b1, 20'h5A5A5, "seq.hs");
    idle(2, "seq");
    step(1'b1, 20'h00000, "seq.hs");
    idle(200, "seq");
    step(1'b1, 20'hFFFFF, "seq.hs");
    step(1'b1, 20'h00015, "seq.hs");
    idle(400, "seq");

    // Randomized requests, some held high across several edges
    for (int i = 0; i < 4000; i++) begin
      logic s;
      logic [19:0] m;
      s = ($urandom_range(0, 11) == 0);
      m = 20'($urandom);
      if ($urandom_range(0, 15) == 0) m = 20'h00015;
      step(s, m, "rand");
    end
    idle(400, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
